edge_det_sequencer: RTL and testbench

//  Controller that sequences the Sobel edge-detection datapath across a full frame. Per

---
 rtl/edge_det_sequencer_pkg.sv | 26 ++
 rtl/edge_det_sequencer_if.sv | 24 ++
 rtl/edge_det_sequencer_addr_gen.sv | 54 +++++
 rtl/edge_det_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_edge_det_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/edge_det_sequencer_pkg.sv
// Shared types and window geometry for the Sobel edge-detection frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package edge_det_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_WRITE,
        S_CLEAR,
        S_ADVANCE
    } seq_state_t;

    // A window is three rows of four pixels. Each window produces two result pixels.
    localparam int unsigned WIN_ROWS    = 3;
    localparam int unsigned WIN_COLS    = 4;
    localparam int unsigned OUT_PER_WIN = 2;

    // A frame needs at least one full window, and an even width so that the
    // two-pixel column stride ends exactly on the last window.
    function automatic logic cfg_legal(input int unsigned w, input int unsigned h);
        return (w >= WIN_COLS) && ((w % 2) == 0) && (h >= WIN_ROWS);
    endfunction

endpackage

// File: rtl/edge_det_sequencer_if.sv
// Memory-transfer handshake between the sequencer (master) and the transfer engine (slave).
// Latency: n/a (signal bundle only).
// Backpressure: requests are levels held until the matching done pulse arrives.
// Signals: rd_req/rd_addr/rd_done = 4-byte row fetch; wr_req/wr_addr/wr_done = 2-byte write-back.
interface edge_det_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_done;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_done;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr,
        input  rd_done, wr_done
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr,
        output rd_done, wr_done
    );
endinterface

// File: rtl/edge_det_sequencer_addr_gen.sv
// Window address generator: fetch address of row r of the window and write-back address.
// Latency: addresses are combinational; the row offset register updates one cycle after row_step.
// Backpressure: none; follows the sequencer's counters.
// Ports: clk/rst; frame_init clears the row offset, row_step adds one row of width;
//        width/base_in/base_out are the latched frame config; col and r select the pixel;
//        rd_addr/wr_addr are the generated addresses (modulo 2^ADDR_W).
module edge_det_addr_gen #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_init,
    input  logic              row_step,
    input  logic [DIM_W-1:0]  width,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [ADDR_W-1:0] base_out,
    input  logic [DIM_W-1:0]  col,
    input  logic [1:0]        r,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr
);
    logic [ADDR_W-1:0] w_ext;
    logic [ADDR_W-1:0] col_ext;
    logic [ADDR_W-1:0] row_off;   // row * width, built by repeated addition
    logic [ADDR_W-1:0] r_off;     // r * width, r is only ever 0..2

    assign w_ext   = ADDR_W'(width);
    assign col_ext = ADDR_W'(col);

    always_ff @(posedge clk) begin
        if (rst) begin
            row_off <= '0;
        end else if (frame_init) begin
            row_off <= '0;
        end else if (row_step) begin
            row_off <= row_off + w_ext;
        end
    end

    always_comb begin
        r_off = '0;
        case (r)
            2'd1:    r_off = w_ext;
            2'd2:    r_off = w_ext << 1;
            default: r_off = '0;
        endcase
    end

    assign rd_addr = base_in + row_off + r_off + col_ext;
    // Result pixel sits at the centre of the window: one row down, one column in.
    assign wr_addr = base_out + row_off + w_ext + col_ext + ADDR_W'(1);

endmodule

// File: rtl/edge_det_sequencer.sv
// Frame sequencer for the Sobel datapath: fetch 3 rows, compute, write back 2 pixels, clear, advance.
// Latency: per window 3 fetches + COMPUTE_LAT compute cycles + 1 write + 2 housekeeping cycles.
// Backpressure: rd_req/wr_req are held until rd_done/wr_done; the FSM waits indefinitely.
// Ports: clk/rst; start/abort control; img_width/img_height/base_in/base_out config (latched at start);
//        mem = fetch/write-back handshake; shift_enable_r, compute_en, buffer_clear drive the datapath;
//        busy is high outside IDLE; frame_done pulses at the end of a frame or on a rejected config.
module edge_det_sequencer
    import edge_det_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DIM_W       = 10,
    parameter int COMPUTE_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DIM_W-1:0]     img_width,
    input  logic [DIM_W-1:0]     img_height,
    input  logic [ADDR_W-1:0]    base_in,
    input  logic [ADDR_W-1:0]    base_out,
    edge_det_sequencer_if.master mem,
    output logic                 shift_enable_r,
    output logic                 compute_en,
    output logic                 buffer_clear,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int LAT_W = (COMPUTE_LAT > 1) ? $clog2(COMPUTE_LAT) : 1;

    seq_state_t        state, state_nxt;
    logic [DIM_W-1:0]  row, col;
    logic [1:0]        r;
    logic [LAT_W-1:0]  lat_cnt;
    logic [DIM_W-1:0]  cfg_w, cfg_h;
    logic [ADDR_W-1:0] cfg_bin, cfg_bout;
    logic              abort_clr_q;
    logic              frame_done_q;

    logic load_cfg, r_inc, r_clr, lat_load, lat_dec;
    logic col_step, row_step, frame_end, cfg_bad, abort_hit, shift;
    logic more_cols, more_rows;

    assign more_cols = ({1'b0, col} + (DIM_W+1)'(WIN_COLS)) < {1'b0, cfg_w};
    assign more_rows = ({1'b0, row} + (DIM_W+1)'(WIN_ROWS)) < {1'b0, cfg_h};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_cfg  = 1'b0;
        r_inc     = 1'b0;
        r_clr     = 1'b0;
        lat_load  = 1'b0;
        lat_dec   = 1'b0;
        col_step  = 1'b0;
        row_step  = 1'b0;
        frame_end = 1'b0;
        cfg_bad   = 1'b0;
        abort_hit = 1'b0;
        shift     = 1'b0;
        // abort overrides everything, including a fetch completing in the same cycle
        if (abort && state != S_IDLE) begin
            abort_hit = 1'b1;
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_legal(32'(img_width), 32'(img_height))) begin
                            load_cfg  = 1'b1;
                            state_nxt = S_LOAD;
                        end else begin
                            cfg_bad = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (mem.rd_done) begin
                        shift = 1'b1;
                        if (r == 2'(WIN_ROWS - 1)) begin
                            lat_load  = 1'b1;
                            state_nxt = S_COMPUTE;
                        end else begin
                            r_inc = 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (lat_cnt == '0) begin
                        state_nxt = S_WRITE;
                    end else begin
                        lat_dec = 1'b1;
                    end
                end
                S_WRITE: begin
                    if (mem.wr_done) begin
                        state_nxt = S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_clr     = 1'b1;
                    state_nxt = S_ADVANCE;
                end
                S_ADVANCE: begin
                    if (more_cols) begin
                        col_step  = 1'b1;
                        state_nxt = S_LOAD;
                    end else if (more_rows) begin
                        row_step  = 1'b1;
                        state_nxt = S_LOAD;
                    end else begin
                        frame_end = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row          <= '0;
            col          <= '0;
            r            <= '0;
            lat_cnt      <= '0;
            cfg_w        <= '0;
            cfg_h        <= '0;
            cfg_bin      <= '0;
            cfg_bout     <= '0;
            abort_clr_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            abort_clr_q  <= abort_hit;
            frame_done_q <= frame_end | cfg_bad;
            if (load_cfg) begin
                cfg_w    <= img_width;
                cfg_h    <= img_height;
                cfg_bin  <= base_in;
                cfg_bout <= base_out;
                row      <= '0;
                col      <= '0;
                r        <= '0;
            end
            if (r_inc) begin
                r <= r + 2'd1;
            end
            if (r_clr || abort_hit) begin
                r <= '0;
            end
            if (lat_load) begin
                lat_cnt <= LAT_W'(COMPUTE_LAT - 1);
            end else if (lat_dec) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (col_step) begin
                col <= col + DIM_W'(OUT_PER_WIN);
            end
            if (row_step) begin
                col <= '0;
                row <= row + DIM_W'(1);
            end
        end
    end

    logic [ADDR_W-1:0] rd_addr_g, wr_addr_g;

    edge_det_addr_gen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .frame_init (load_cfg),
        .row_step   (row_step),
        .width      (cfg_w),
        .base_in    (cfg_bin),
        .base_out   (cfg_bout),
        .col        (col),
        .r          (r),
        .rd_addr    (rd_addr_g),
        .wr_addr    (wr_addr_g)
    );

    // The fetch request drops in the cycle its completion arrives, so the
    // following row's request starts cleanly on the next cycle.
    assign mem.rd_req   = (state == S_LOAD) && !mem.rd_done;
    assign mem.rd_addr  = rd_addr_g;
    assign mem.wr_req   = (state == S_WRITE);
    assign mem.wr_addr  = wr_addr_g;
    assign shift_enable_r = shift;
    assign compute_en   = (state == S_COMPUTE);
    assign buffer_clear = (state == S_CLEAR) || abort_clr_q;
    assign busy         = (state != S_IDLE);
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_edge_det_sequencer.sv
module tb_edge_det_sequencer;
    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [9:0]  img_width;
    logic [9:0]  img_height;
    logic [15:0] base_in;
    logic [15:0] base_out;
    logic        shift_enable_r;
    logic        compute_en;
    logic        buffer_clear;
    logic        busy;
    logic        frame_done;

    edge_det_sequencer_if #(.ADDR_W(16)) mem ();

    edge_det_sequencer #(
        .ADDR_W      (16),
        .DIM_W       (10),
        .COMPUTE_LAT (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .img_width      (img_width),
        .img_height     (img_height),
        .base_in        (base_in),
        .base_out       (base_out),
        .mem            (mem),
        .shift_enable_r (shift_enable_r),
        .compute_en     (compute_en),
        .buffer_clear   (buffer_clear),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] rd_log[$];
    logic [15:0] wr_log[$];
    logic [15:0] exp_rd[$];
    logic [15:0] exp_wr[$];
    int n_compute, n_clear, n_frame, n_wrreq;
    int rcnt, wcnt;
    bit rd_rsp_en, wr_rsp_en, stray_en;
    bit prev_wr, prev_comp;

    task automatic clear_logs();
        rd_log.delete();
        wr_log.delete();
        n_compute = 0;
        n_clear   = 0;
        n_frame   = 0;
        n_wrreq   = 0;
        rcnt      = 0;
        wcnt      = 0;
        prev_wr   = 0;
        prev_comp = 0;
    endtask

    // Expected window addresses, window order row-major, rows r=0..2 within a window.
    task automatic build_exp(input int w, input int h, input int bin, input int bout);
        exp_rd.delete();
        exp_wr.delete();
        for (int row = 0; row <= h - 3; row++) begin
            for (int col = 0; col <= w - 4; col += 2) begin
                for (int rr = 0; rr < 3; rr++) begin
                    exp_rd.push_back(16'(bin + (row + rr) * w + col));
                end
                exp_wr.push_back(16'(bout + (row + 1) * w + col + 1));
            end
        end
    endtask

    // One clock: observe at the falling edge, respond as the transfer engine,
    // then apply new done levels just after the rising edge.
    task automatic tick();
        logic nrd, nwr;
        @(negedge clk);
        if (shift_enable_r) rd_log.push_back(mem.rd_addr);
        if (mem.wr_req && mem.wr_done) wr_log.push_back(mem.wr_addr);
        if (compute_en) n_compute++;
        if (buffer_clear) n_clear++;
        if (frame_done) n_frame++;
        if (mem.wr_req && !prev_wr) n_wrreq++;
        prev_wr = mem.wr_req;
        nrd = mem.rd_done;
        nwr = mem.wr_done;
        if (rd_rsp_en) begin
            if (mem.rd_done) begin nrd = 1'b0; rcnt = 0; end
            else if (mem.rd_req) begin rcnt++; nrd = (rcnt == 4); end
            else rcnt = 0;
        end
        if (wr_rsp_en) begin
            if (mem.wr_done) begin nwr = 1'b0; wcnt = 0; end
            else if (mem.wr_req) begin wcnt++; nwr = (wcnt == 2); end
            else wcnt = 0;
        end
        if (stray_en && compute_en && !prev_comp) begin
            nrd = 1'b1;
            nwr = 1'b1;
        end
        prev_comp = compute_en;
        @(posedge clk);
        #1;
        mem.rd_done = nrd;
        mem.wr_done = nwr;
    endtask

    task automatic run_to_idle(input int max_cyc, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (!busy) begin
                tick();
                timed_out = 1'b0;
                return;
            end
        end
    endtask

    task automatic start_frame(input int w, input int h, input int bin, input int bout);
        img_width  = 10'(w);
        img_height = 10'(h);
        base_in    = 16'(bin);
        base_out   = 16'(bout);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        img_width = '0; img_height = '0; base_in = '0; base_out = '0;
        mem.rd_done = 1'b0; mem.wr_done = 1'b0;
        rd_rsp_en = 1'b1; wr_rsp_en = 1'b1; stray_en = 1'b0;
        clear_logs();
        repeat (3) tick();
        n_cmp++;
        if ({busy, mem.rd_req, mem.wr_req, compute_en, shift_enable_r, buffer_clear, frame_done} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0000000",
                     {busy, mem.rd_req, mem.wr_req, compute_en, shift_enable_r, buffer_clear, frame_done});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_frame();
        bit to;
        clear_logs();
        build_exp(8, 4, 0, 'h1000);
        start_frame(8, 4, 0, 'h1000);
        run_to_idle(2000, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL full_timeout: frame still busy after 2000 cycles"); end
        n_cmp++; if (rd_log.size() != 18) begin n_err++; $display("FAIL full_rd_count: got %0d want 18", rd_log.size()); end
        n_cmp++; if (wr_log.size() != 6) begin n_err++; $display("FAIL full_wr_count: got %0d want 6", wr_log.size()); end
        for (int i = 0; i < 18; i++) begin
            n_cmp++;
            if (rd_log[i] !== exp_rd[i]) begin n_err++; $display("FAIL full_rd[%0d]: got %h want %h", i, rd_log[i], exp_rd[i]); end
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (wr_log[i] !== exp_wr[i]) begin n_err++; $display("FAIL full_wr[%0d]: got %h want %h", i, wr_log[i], exp_wr[i]); end
        end
        n_cmp++;
        if ({rd_log[0], rd_log[1], rd_log[2]} !== {16'd0, 16'd8, 16'd16}) begin
            n_err++; $display("FAIL full_first_rd: got %h %h %h want 0 8 16", rd_log[0], rd_log[1], rd_log[2]);
        end
        n_cmp++;
        if ({rd_log[15], rd_log[16], rd_log[17]} !== {16'd12, 16'd20, 16'd28}) begin
            n_err++; $display("FAIL full_last_rd: got %h %h %h want c 14 1c", rd_log[15], rd_log[16], rd_log[17]);
        end
        n_cmp++; if (wr_log[0] !== 16'h1009) begin n_err++; $display("FAIL full_first_wr: got %h want 1009", wr_log[0]); end
        n_cmp++; if (wr_log[5] !== 16'h1015) begin n_err++; $display("FAIL full_last_wr: got %h want 1015", wr_log[5]); end
        n_cmp++; if (n_frame != 1) begin n_err++; $display("FAIL full_frame_done: got %0d pulses want 1", n_frame); end
        n_cmp++; if (n_clear != 6) begin n_err++; $display("FAIL full_clears: got %0d want 6", n_clear); end
        n_cmp++; if (n_compute != 12) begin n_err++; $display("FAIL full_compute: got %0d cycles want 12", n_compute); end
    endtask

    task automatic test_one_window();
        bit to;
        clear_logs();
        start_frame(4, 3, 'h40, 'h80);
        run_to_idle(500, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL one_timeout: frame still busy after 500 cycles"); end
        n_cmp++; if (rd_log.size() != 3) begin n_err++; $display("FAIL one_shifts: got %0d want 3", rd_log.size()); end
        n_cmp++;
        if ({rd_log[0], rd_log[1], rd_log[2]} !== {16'h40, 16'h44, 16'h48}) begin
            n_err++; $display("FAIL one_rd_addr: got %h %h %h want 40 44 48", rd_log[0], rd_log[1], rd_log[2]);
        end
        n_cmp++; if (n_compute != 2) begin n_err++; $display("FAIL one_compute: got %0d want 2", n_compute); end
        n_cmp++; if (n_wrreq != 1) begin n_err++; $display("FAIL one_wr_req: got %0d want 1", n_wrreq); end
        n_cmp++; if (wr_log[0] !== 16'h85) begin n_err++; $display("FAIL one_wr_addr: got %h want 85", wr_log[0]); end
        n_cmp++; if (n_clear != 1) begin n_err++; $display("FAIL one_clear: got %0d want 1", n_clear); end
        n_cmp++; if (n_frame != 1) begin n_err++; $display("FAIL one_frame_done: got %0d want 1", n_frame); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL one_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_abort();
        bit reached;
        clear_logs();
        reached = 1'b0;
        start_frame(8, 4, 0, 'h1000);
        for (int i = 0; i < 100 && !reached; i++) begin
            tick();
            reached = (rd_log.size() >= 1);
        end
        n_cmp++; if (!reached) begin n_err++; $display("FAIL abort_setup: first row fetch never completed"); end
        // second fetch of the window is pending; complete it and abort together
        rd_rsp_en   = 1'b0;
        mem.rd_done = 1'b1;
        abort       = 1'b1;
        tick();
        mem.rd_done = 1'b0;
        abort       = 1'b0;
        n_cmp++; if (buffer_clear !== 1'b1) begin n_err++; $display("FAIL abort_clear: got %b want 1", buffer_clear); end
        n_cmp++; if (mem.rd_req !== 1'b0) begin n_err++; $display("FAIL abort_rd_req: got %b want 0", mem.rd_req); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (rd_log.size() != 1) begin n_err++; $display("FAIL abort_shift: got %0d shifts want 1", rd_log.size()); end
        rd_rsp_en = 1'b1;
        repeat (20) tick();
        n_cmp++; if (n_frame != 0) begin n_err++; $display("FAIL abort_frame_done: got %0d pulses want 0", n_frame); end
        n_cmp++; if (n_clear != 1) begin n_err++; $display("FAIL abort_clear_count: got %0d want 1", n_clear); end
    endtask

    task automatic test_ignored_inputs();
        bit to;
        bit reached;
        clear_logs();
        build_exp(8, 4, 0, 'h1000);
        stray_en = 1'b1;
        reached  = 1'b0;
        start_frame(8, 4, 0, 'h1000);
        for (int i = 0; i < 300 && !reached; i++) begin
            tick();
            reached = (rd_log.size() >= 5);
        end
        n_cmp++; if (!reached) begin n_err++; $display("FAIL ign_setup: fewer than 5 fetches completed"); end
        start_frame(4, 3, 'h777, 'h2000);
        run_to_idle(2000, to);
        stray_en = 1'b0;
        n_cmp++; if (to) begin n_err++; $display("FAIL ign_timeout: frame still busy after 2000 cycles"); end
        n_cmp++; if (rd_log.size() != 18) begin n_err++; $display("FAIL ign_rd_count: got %0d want 18", rd_log.size()); end
        n_cmp++; if (wr_log.size() != 6) begin n_err++; $display("FAIL ign_wr_count: got %0d want 6", wr_log.size()); end
        for (int i = 0; i < 18; i++) begin
            n_cmp++;
            if (rd_log[i] !== exp_rd[i]) begin n_err++; $display("FAIL ign_rd[%0d]: got %h want %h", i, rd_log[i], exp_rd[i]); end
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (wr_log[i] !== exp_wr[i]) begin n_err++; $display("FAIL ign_wr[%0d]: got %h want %h", i, wr_log[i], exp_wr[i]); end
        end
        n_cmp++; if (n_frame != 1) begin n_err++; $display("FAIL ign_frame_done: got %0d pulses want 1", n_frame); end
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        bit reached;
        clear_logs();
        wr_rsp_en = 1'b0;
        reached   = 1'b0;
        start_frame(8, 4, 'h200, 'h1000);
        for (int i = 0; i < 300 && !reached; i++) begin
            tick();
            reached = mem.wr_req;
        end
        n_cmp++; if (!reached) begin n_err++; $display("FAIL rst_setup: WRITE never reached"); end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({busy, mem.rd_req, mem.wr_req, compute_en, shift_enable_r, buffer_clear, frame_done} !== 7'b0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got %b want 0000000",
                     {busy, mem.rd_req, mem.wr_req, compute_en, shift_enable_r, buffer_clear, frame_done});
        end
        rst = 1'b0;
        tick();
        n_cmp++; if (n_clear != 0) begin n_err++; $display("FAIL rst_mid_clear: got %0d clears want 0", n_clear); end
        wr_rsp_en = 1'b1;
        start_frame(8, 4, 'h300, 'h1000);
        n_cmp++;
        if (mem.rd_req !== 1'b1 || mem.rd_addr !== 16'h300) begin
            n_err++; $display("FAIL rst_restart: got rd_req=%b rd_addr=%h want 1 0300", mem.rd_req, mem.rd_addr);
        end
        run_to_idle(2000, to);
        n_cmp++; if (to || n_frame != 1) begin n_err++; $display("FAIL rst_restart_frame: timeout=%b frame_done=%0d want 0 1", to, n_frame); end
    endtask

    task automatic test_illegal_cfg();
        clear_logs();
        start_frame(5, 4, 0, 0);
        n_cmp++;
        if ({frame_done, busy, mem.rd_req} !== 3'b100) begin
            n_err++; $display("FAIL bad_w5: got frame_done,busy,rd_req=%b want 100", {frame_done, busy, mem.rd_req});
        end
        tick();
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL bad_w5_pulse: got %b want 0", frame_done); end
        start_frame(8, 2, 0, 0);
        n_cmp++;
        if ({frame_done, busy, mem.rd_req} !== 3'b100) begin
            n_err++; $display("FAIL bad_h2: got frame_done,busy,rd_req=%b want 100", {frame_done, busy, mem.rd_req});
        end
        repeat (3) tick();
        n_cmp++; if (rd_log.size() != 0 || busy !== 1'b0) begin n_err++; $display("FAIL bad_no_fetch: got shifts=%0d busy=%b want 0 0", rd_log.size(), busy); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_one_window();
        test_abort();
        test_ignored_inputs();
        test_reset_mid_frame();
        test_illegal_cfg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
